// File: rtl/list_pkg.sv
// Shared types and constants for the list block and its command master.
package list_pkg;

  localparam int unsigned LIST_DW     = 32;
  localparam int unsigned LIST_LENGTH = 8;
  localparam int unsigned LIST_LW     = $clog2(LIST_LENGTH);
  localparam int unsigned LIST_RW     = LIST_LW + LIST_DW;

  localparam logic [2:0] OP_READ       = 3'd0;
  localparam logic [2:0] OP_INSERT     = 3'd1;
  localparam logic [2:0] OP_FIND_ALL   = 3'd2;
  localparam logic [2:0] OP_FIND_FIRST = 3'd3;
  localparam logic [2:0] OP_SUM        = 3'd4;
  localparam logic [2:0] OP_SORT_ASC   = 3'd5;
  localparam logic [2:0] OP_SORT_DESC  = 3'd6;
  localparam logic [2:0] OP_DELETE     = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_GAP,
    ST_DRAIN
  } master_state_e;

  typedef struct packed {
    logic [LIST_RW-1:0] data;
    logic               error;
    logic               last;
    logic               timeout;
  } list_rsp_t;

  function automatic logic is_find(input logic [2:0] op);
    return (op == OP_FIND_ALL) || (op == OP_FIND_FIRST);
  endfunction

endpackage

// File: rtl/list_rsp_fifo.sv
// Response buffer: registered-output synchronous FIFO, no fall-through.
module list_rsp_fifo
  import list_pkg::*;
#(
  parameter int unsigned DEPTH = LIST_LENGTH + 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  list_rsp_t                  push_data,
  input  logic                       pop,
  output list_rsp_t                  pop_data,
  output logic                       valid,
  output logic [$clog2(DEPTH+1)-1:0] free_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  list_rsp_t         mem_q [DEPTH];
  list_rsp_t         mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : PW'(p + 1'b1);
  endfunction

  assign do_pop = pop && (count_q != '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, do_pop})
      2'b10:   count_d = CW'(count_q + 1'b1);
      2'b01:   count_d = CW'(count_q - 1'b1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign pop_data   = mem_q[rd_ptr_q];
  assign valid      = (count_q != '0);
  assign free_count = CW'(DEPTH) - count_q;

  // The master reserves room for every push, so a push into a full buffer is a design error.
  assert property (@(posedge clk) disable iff (rst)
    !(push && (count_q == CW'(DEPTH)) && !do_pop));

endmodule

// File: rtl/list_master.sv
// Command initiator for the list: issues one op at a time and buffers every completion.
module list_master
  import list_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = LIST_DW,
  parameter int unsigned LENGTH     = LIST_LENGTH,
  parameter int unsigned TIMEOUT    = 256,
  parameter int unsigned FIFO_DEPTH = LENGTH + 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 cmd_valid,
  output logic                                 cmd_ready,
  input  logic [2:0]                           cmd_op,
  input  logic [DATA_WIDTH-1:0]                cmd_data,
  input  logic [$clog2(LENGTH)-1:0]            cmd_index,
  output logic [2:0]                           op_sel,
  output logic                                 op_en,
  output logic [DATA_WIDTH-1:0]                data_in,
  output logic [$clog2(LENGTH)-1:0]            index_in,
  input  logic [$clog2(LENGTH)+DATA_WIDTH-1:0] data_out,
  input  logic                                 op_done,
  input  logic                                 op_in_progress,
  input  logic                                 op_error,
  input  logic [$clog2(LENGTH+1)-1:0]          list_len,
  output logic                                 rsp_valid,
  input  logic                                 rsp_ready,
  output logic [$clog2(LENGTH)+DATA_WIDTH-1:0] rsp_data,
  output logic                                 rsp_error,
  output logic                                 rsp_last,
  output logic                                 rsp_timeout
);

  localparam int unsigned LW  = $clog2(LENGTH);
  localparam int unsigned FW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned WDW = $clog2(TIMEOUT + 1);

  master_state_e          state_q, state_d;
  logic [2:0]             op_sel_q, op_sel_d;
  logic                   op_en_q, op_en_d;
  logic [DATA_WIDTH-1:0]  data_in_q, data_in_d;
  logic [LW-1:0]          index_in_q, index_in_d;
  logic [WDW-1:0]         wd_q, wd_d;

  logic                   push;
  list_rsp_t              push_rsp;
  list_rsp_t              rsp_head;
  logic [FW-1:0]          free_count;
  logic                   terminal;
  logic                   term_error;

  assign cmd_ready  = (state_q == ST_IDLE) && (free_count >= FW'(LENGTH + 1));
  assign terminal   = op_done && !op_in_progress;
  // Find-all reports "found" on op_error, so a clean find-all is one with the flag set.
  assign term_error = (op_sel_q == OP_FIND_ALL) ? !op_error : op_error;

  always_comb begin
    state_d    = state_q;
    op_sel_d   = op_sel_q;
    op_en_d    = 1'b0;
    data_in_d  = data_in_q;
    index_in_d = index_in_q;
    wd_d       = wd_q;
    push       = 1'b0;
    push_rsp   = '0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (is_find(cmd_op) && (list_len == '0)) begin
            push           = 1'b1;
            push_rsp.error = 1'b1;
            push_rsp.last  = 1'b1;
          end else begin
            op_sel_d   = cmd_op;
            data_in_d  = cmd_data;
            index_in_d = cmd_index;
            op_en_d    = 1'b1;
            wd_d       = '0;
            state_d    = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        wd_d = WDW'(wd_q + 1'b1);
        if (terminal) begin
          push           = 1'b1;
          push_rsp.data  = term_error ? '0 : data_out;
          push_rsp.error = term_error;
          push_rsp.last  = 1'b1;
          state_d        = ST_GAP;
        end else if (wd_q == WDW'(TIMEOUT - 1)) begin
          push             = 1'b1;
          push_rsp.error   = 1'b1;
          push_rsp.last    = 1'b1;
          push_rsp.timeout = 1'b1;
          state_d          = ST_DRAIN;
        end else if (op_done) begin
          push          = 1'b1;
          push_rsp.data = data_out;
        end
      end
      ST_DRAIN: begin
        if (terminal) state_d = ST_GAP;
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_sel_q   <= '0;
      op_en_q    <= 1'b0;
      data_in_q  <= '0;
      index_in_q <= '0;
      wd_q       <= '0;
    end else begin
      state_q    <= state_d;
      op_sel_q   <= op_sel_d;
      op_en_q    <= op_en_d;
      data_in_q  <= data_in_d;
      index_in_q <= index_in_d;
      wd_q       <= wd_d;
    end
  end

  list_rsp_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_rsp),
    .pop       (rsp_ready),
    .pop_data  (rsp_head),
    .valid     (rsp_valid),
    .free_count(free_count)
  );

  assign op_sel      = op_sel_q;
  assign op_en       = op_en_q;
  assign data_in     = data_in_q;
  assign index_in    = index_in_q;
  assign rsp_data    = rsp_head.data;
  assign rsp_error   = rsp_head.error;
  assign rsp_last    = rsp_head.last;
  assign rsp_timeout = rsp_head.timeout;

endmodule

// File: tb/tb_list_master.sv
// Bench for list_master against a behavioural list stub, with a response scoreboard.
module tb_list_master;
  import list_pkg::*;

  localparam int DW  = LIST_DW;
  localparam int LEN = LIST_LENGTH;
  localparam int LW  = LIST_LW;
  localparam int RW  = LIST_RW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid, cmd_ready;
  logic [2:0]    cmd_op;
  logic [DW-1:0] cmd_data;
  logic [LW-1:0] cmd_index;
  logic [2:0]    op_sel;
  logic          op_en;
  logic [DW-1:0] data_in;
  logic [LW-1:0] index_in;
  logic [RW-1:0] data_out;
  logic          op_done, op_in_progress, op_error;
  logic [3:0]    list_len;
  logic          rsp_valid, rsp_ready;
  logic [RW-1:0] rsp_data;
  logic          rsp_error, rsp_last, rsp_timeout;

  always #5 clk = ~clk;

  list_master #(.TIMEOUT(256)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_index(cmd_index),
    .op_sel(op_sel), .op_en(op_en), .data_in(data_in), .index_in(index_in),
    .data_out(data_out), .op_done(op_done), .op_in_progress(op_in_progress),
    .op_error(op_error), .list_len(list_len), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .rsp_last(rsp_last), .rsp_timeout(rsp_timeout)
  );

  // ---------------- behavioural list stub ----------------
  logic [DW-1:0] mem [LEN];
  logic [3:0]    s_len, s_idx;
  logic [7:0]    s_busy;
  logic          s_done, s_prog, s_err, s_scan, s_found;
  logic [RW-1:0] s_dout;
  logic [DW-1:0] s_key;
  logic          mute = 1'b0;
  logic          term_req = 1'b0;

  assign op_done        = s_done;
  assign op_in_progress = s_prog;
  assign op_error       = s_err;
  assign data_out       = s_dout;
  assign list_len       = s_len;

  function automatic int find_first(input logic [DW-1:0] key);
    for (int i = 0; i < LEN; i++)
      if (i < int'(s_len) && mem[i] == key) return i;
    return -1;
  endfunction

  function automatic logic [DW-1:0] sum_all();
    logic [DW-1:0] acc = '0;
    for (int i = 0; i < LEN; i++)
      if (i < int'(s_len)) acc = acc + mem[i];
    return acc;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_len <= '0; s_idx <= '0; s_busy <= '0; s_done <= 1'b0; s_prog <= 1'b0;
      s_err <= 1'b0; s_scan <= 1'b0; s_found <= 1'b0; s_dout <= '0; s_key <= '0;
      for (int i = 0; i < LEN; i++) mem[i] <= '0;
    end else begin
      s_done <= 1'b0; s_prog <= 1'b0; s_err <= 1'b0; s_dout <= '0;
      if (term_req) begin
        s_done <= 1'b1;
      end else if (s_scan) begin
        if (s_idx < s_len) begin
          if (mem[s_idx[2:0]] == s_key) begin
            s_done <= 1'b1; s_prog <= 1'b1; s_dout <= RW'(s_idx); s_found <= 1'b1;
          end
          s_idx <= s_idx + 4'd1;
        end else begin
          s_done <= 1'b1; s_err <= s_found; s_scan <= 1'b0;
        end
      end else if (s_busy != 8'd0) begin
        s_busy <= s_busy - 8'd1;
        if (s_busy == 8'd1) s_done <= 1'b1;
      end else if (op_en && !mute) begin
        case (op_sel)
          OP_READ: begin
            s_done <= 1'b1;
            if (4'(index_in) < s_len) s_dout <= RW'(mem[index_in]);
            else s_err <= 1'b1;
          end
          OP_INSERT: begin
            s_done <= 1'b1;
            if (s_len == 4'(LEN) || 4'(index_in) > s_len) s_err <= 1'b1;
            else begin
              for (int j = 1; j < LEN; j++)
                if (j > int'(index_in) && j <= int'(s_len)) mem[j] <= mem[j-1];
              mem[index_in] <= data_in;
              s_len <= s_len + 4'd1;
            end
          end
          OP_FIND_ALL: begin
            s_scan <= 1'b1; s_idx <= '0; s_found <= 1'b0; s_key <= data_in;
          end
          OP_FIND_FIRST: begin
            s_done <= 1'b1;
            if (find_first(data_in) < 0) s_err <= 1'b1;
            else s_dout <= RW'(find_first(data_in));
          end
          OP_SUM: begin
            s_done <= 1'b1; s_dout <= RW'(sum_all());
          end
          OP_DELETE: begin
            s_done <= 1'b1;
            if (4'(index_in) < s_len) begin
              for (int j = 0; j < LEN - 1; j++)
                if (j >= int'(index_in) && j < int'(s_len) - 1) mem[j] <= mem[j+1];
              s_len <= s_len - 4'd1;
            end else s_err <= 1'b1;
          end
          default: s_busy <= 8'd60;
        endcase
      end
    end
  end

  // ---------------- scoreboard and monitors ----------------
  int        n_pass = 0;
  int        n_total = 0;
  int        n_rsp = 0;
  int        cyc = 0;
  int        en_cnt = 0, en_last = 0, en_prev = 0;
  list_rsp_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, got, want);
  endtask

  task automatic expect_rsp(input logic [RW-1:0] d, input logic er, input logic la, input logic to);
    list_rsp_t e;
    e.data = d; e.error = er; e.last = la; e.timeout = to;
    exp_q.push_back(e);
  endtask

  initial forever begin
    @(negedge clk);
    if (op_en) begin
      en_cnt++; en_prev = en_last; en_last = cyc;
    end
  end

  initial forever begin
    list_rsp_t e;
    logic [63:0] got;
    @(negedge clk);
    if (!rst && rsp_valid && rsp_ready) begin
      got = 64'({rsp_data, rsp_error, rsp_last, rsp_timeout});
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL rsp_unexpected: got %0h want no response", got);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("rsp%0d", n_rsp), got, 64'(e));
      end
      n_rsp++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input logic [2:0] op, input logic [DW-1:0] d, input logic [LW-1:0] idx);
    int i;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_index = idx;
    for (i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    check("cmd_accept", 64'(i < 2000), 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int i;
    for (i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
    check(name, 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clk);
  endtask

  task automatic wait_valid(output int lat);
    int i;
    for (i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    lat = cyc - en_last;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int c0, lat;
    cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_index = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("rst_op_en", 64'(op_en), 64'd0);
    check("rst_op_sel", 64'(op_sel), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    rst = 1'b0;

    // find-first on an empty list never reaches the list
    c0 = en_cnt;
    expect_rsp('0, 1'b1, 1'b1, 1'b0);
    issue(OP_FIND_FIRST, 32'd9, '0);
    drain("ff_empty_drain");
    check("ff_empty_no_op_en", 64'(en_cnt - c0), 64'd0);

    expect_rsp('0, 1'b0, 1'b1, 1'b0); issue(OP_INSERT, 32'd5, 3'd0);
    expect_rsp('0, 1'b0, 1'b1, 1'b0); issue(OP_INSERT, 32'd7, 3'd1);
    @(negedge clk); #1;
    check("b2b_issue_spacing", 64'(en_last - en_prev), 64'd4);
    expect_rsp('0, 1'b0, 1'b1, 1'b0); issue(OP_INSERT, 32'd5, 3'd2);
    drain("ins_drain");

    expect_rsp(RW'(0), 1'b0, 1'b0, 1'b0);
    expect_rsp(RW'(2), 1'b0, 1'b0, 1'b0);
    expect_rsp('0, 1'b0, 1'b1, 1'b0);
    issue(OP_FIND_ALL, 32'd5, '0);
    drain("fa5_drain");

    c0 = en_cnt;
    expect_rsp('0, 1'b1, 1'b1, 1'b0);
    issue(OP_READ, '0, 3'd3);
    wait_valid(lat);
    check("read_latency", 64'(lat), 64'd2);
    drain("read_oob_drain");
    check("read_op_en_once", 64'(en_cnt - c0), 64'd1);

    expect_rsp(RW'(7), 1'b0, 1'b1, 1'b0);  issue(OP_READ, '0, 3'd1);         drain("read1_drain");
    expect_rsp(RW'(1), 1'b0, 1'b1, 1'b0);  issue(OP_FIND_FIRST, 32'd7, '0);  drain("ff7_drain");
    expect_rsp('0, 1'b1, 1'b1, 1'b0);      issue(OP_FIND_ALL, 32'd9, '0);    drain("fa9_drain");
    expect_rsp(RW'(17), 1'b0, 1'b1, 1'b0); issue(OP_SUM, '0, '0);            drain("sum_drain");
    expect_rsp('0, 1'b0, 1'b1, 1'b0);      issue(OP_DELETE, '0, 3'd1);       drain("del_drain");
    expect_rsp(RW'(0), 1'b0, 1'b0, 1'b0);
    expect_rsp(RW'(1), 1'b0, 1'b0, 1'b0);
    expect_rsp('0, 1'b0, 1'b1, 1'b0);
    issue(OP_FIND_ALL, 32'd5, '0);
    drain("fa_after_del_drain");

    // asynchronous reset in the middle of a long sort
    issue(OP_SORT_DESC, 32'h55, 3'd3);
    repeat (10) @(posedge clk); #2;
    check("sort_op_sel", 64'(op_sel), 64'(OP_SORT_DESC));
    rst = 1'b1; #1;
    check("midrst_op_en", 64'(op_en), 64'd0);
    check("midrst_op_sel", 64'(op_sel), 64'd0);
    check("midrst_data_in", 64'(data_in), 64'd0);
    check("midrst_index_in", 64'(index_in), 64'd0);
    check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    expect_rsp('0, 1'b0, 1'b1, 1'b0); issue(OP_INSERT, 32'd4, 3'd0);
    drain("ins_after_rst_drain");

    for (int k = 1; k < LEN; k++) begin
      expect_rsp('0, 1'b0, 1'b1, 1'b0);
      issue(OP_INSERT, 32'd4, LW'(k));
    end
    drain("fill_drain");
    expect_rsp('0, 1'b1, 1'b1, 1'b0); issue(OP_INSERT, 32'd4, 3'd0);
    drain("ins_full_drain");

    // full-list find-all with the consumer stalled
    rsp_ready = 1'b0;
    for (int k = 0; k < LEN; k++) expect_rsp(RW'(k), 1'b0, 1'b0, 1'b0);
    expect_rsp('0, 1'b0, 1'b1, 1'b0);
    issue(OP_FIND_ALL, 32'd4, '0);
    repeat (20) @(posedge clk); #1;
    check("stall_cmd_ready", 64'(cmd_ready), 64'd0);
    check("stall_rsp_valid", 64'(rsp_valid), 64'd1);
    check("stall_held", 64'(exp_q.size()), 64'd9);
    rsp_ready = 1'b1;
    drain("fa_full_drain");
    check("drained_cmd_ready", 64'(cmd_ready), 64'd1);

    // list never answers: watchdog, then a late completion is swallowed
    mute = 1'b1;
    expect_rsp('0, 1'b1, 1'b1, 1'b1);
    issue(OP_READ, '0, 3'd2);
    wait_valid(lat);
    check("timeout_latency", 64'(lat), 64'd257);
    drain("timeout_drain");
    repeat (10) @(posedge clk); #1;
    term_req = 1'b1;
    @(posedge clk); #1;
    term_req = 1'b0;
    mute = 1'b0;
    repeat (5) @(posedge clk);
    expect_rsp(RW'(4), 1'b0, 1'b1, 1'b0); issue(OP_READ, '0, 3'd2);
    drain("read_after_timeout_drain");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/list_master.md
# list_master

Command initiator for the `list` block: accepts list commands on a valid/ready stream, drives the list's `op_sel`/`op_en` port with correct pulse and hold rules, and collects completions. Every completion, including each match of a find-all search, is returned on a buffered valid/ready response stream. It sits between a host/CSR front end and the list, so software-side logic never has to handle multi-cycle and multi-result list timing.

## Interface
- `DATA_WIDTH`, 32, element width; must match the list.
- `LENGTH`, 8, list capacity; must match the list. `LW = $clog2(LENGTH)`.
- `TIMEOUT`, 256, maximum cycles allowed between issue and terminal completion; must be ≥ `LENGTH*LENGTH+4`.
- `FIFO_DEPTH`, `LENGTH+2`, response buffer depth; must be ≥ `LENGTH+1`.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted when high together with `cmd_valid`.
- `cmd_op` in 3: opcode. 0 read, 1 insert, 2 find-all, 3 find-first, 4 sum, 5 sort-asc, 6 sort-desc, 7 delete.
- `cmd_data` in DATA_WIDTH: insert value or search key.
- `cmd_index` in LW: read/insert/delete index.
- `op_sel` out 3: to list.
- `op_en` out 1: to list.
- `data_in` out DATA_WIDTH: to list.
- `index_in` out LW: to list.
- `data_out` in LW+DATA_WIDTH: from list.
- `op_done` in 1: from list.
- `op_in_progress` in 1: from list.
- `op_error` in 1: from list.
- `list_len` in $clog2(LENGTH+1): current list length, from the list's `len`.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: response consumed when high together with `rsp_valid`.
- `rsp_data` out LW+DATA_WIDTH: result payload.
- `rsp_error` out 1: operation failed.
- `rsp_last` out 1: final response of the command.
- `rsp_timeout` out 1: watchdog expired.

## Operation
- States: IDLE, ISSUE, WAIT, GAP, DRAIN.
- IDLE:
  - `cmd_ready = (fifo_free >= LENGTH+1)`.
  - On accept, register op/data/index, then go to ISSUE.
  - Exception: find-all or find-first with `list_len == 0` pushes {data 0, error 1, last 1}, does not issue, and goes to IDLE.
- ISSUE:
  - `op_en = 1` for exactly one cycle, then go to WAIT.
  - `op_sel`, `data_in` and `index_in` stay stable from ISSUE until leaving WAIT or DRAIN.
- WAIT, each cycle:
  - `op_done & op_in_progress` (find-all match): push {`data_out`, error 0, last 0}.
  - `op_done & !op_in_progress` (terminal): push {data, error, last 1}, then go to GAP.
    - Data is 0 when error is set, otherwise `data_out`.
    - For find-all, error = `!op_error`: the list flags "found" on that line at the terminal cycle.
  - Watchdog reaches TIMEOUT: push {0, error 1, last 1, timeout 1}, then go to DRAIN.
- DRAIN: discard list completions until a terminal completion, then go to GAP.
- GAP: one idle cycle covers the list's post-completion cycle, in which it ignores `op_en`. Then go to IDLE.
- `op_en` is never high outside ISSUE.
- The FIFO reserves room for LENGTH matches plus the terminal, so no push is ever dropped. A push while full is an assertion failure.
- Reset values:
  - State is IDLE; `op_en`, `op_sel`, `data_in` and `index_in` are 0.
  - FIFO is empty and the watchdog is 0.
  - `rsp_valid` is 0, `rsp_*` are 0, `cmd_ready` is 1 (FIFO empty).
- Reset mid-operation clears everything immediately. The list shares `rst`.

## Timing
- Accept at edge T0 → `op_en` high in cycle T0+1.
- For a single-cycle list op, `op_done` appears in cycle T0+2 and the pushed response is `rsp_valid` in cycle T0+3.
- The next command is accepted no earlier than edge T0+4, so back-to-back single-cycle ops issue every 4 cycles.
- Response FIFO is registered output with no fall-through: push at edge N → visible in cycle N+1. Simultaneous push and pop are allowed.
- Watchdog counts cycles in WAIT from the first WAIT cycle. It clears on entry to ISSUE; intermediate matches do not clear it.
- Find-all with k matches produces k+1 responses. Consecutive matching elements give `op_done` high on consecutive cycles, one push per cycle.

## Structure
- `list_pkg`:
  - opcode localparams (OP_READ…OP_DELETE);
  - master state enum;
  - response struct {data, error, last, timeout}.
- Sub-module `list_rsp_fifo`: a synchronous FIFO of response structs with a `free_count` output.
- Optional shared testbench instantiating `list` + `list_master` back to back.

## Test plan
- Insert 5, 7, 5 at index 0, 1, 2, then find-all key 5 → responses {0, err 0, last 0}, {2, err 0, last 0}, {0, err 0, last 1}.
- Read index 3 on a 3-element list → a single response with err 1, last 1, data 0. `op_en` is high exactly one cycle.
- Find-first key 9 with `list_len == 0` → immediate response with err 1, last 1. `op_en` never asserts.
- Hold `rsp_ready = 0`, fill 8 elements all equal to 4, find-all 4 → `cmd_ready` low until the FIFO drains. Then 9 responses, indices 0..7, with the last one flagged `last`.
- Stub the list so it never completes → after 256 WAIT cycles, response {err 1, timeout 1, last 1}. A later terminal `op_done` is swallowed, and the next command works.
- Assert `rst` during a sort-desc → all outputs return to their reset values the same cycle, and the next insert succeeds with data 0.
